// File: rtl/dcache_pkg.sv
// Shared constants, flush-state encoding and helpers for the associative data-cache array.
package dcache_pkg;

  localparam int DEF_SETS   = 128;
  localparam int DEF_WAYS   = 2;
  localparam int DEF_TAG_W  = 22;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_SCAN = 2'd1,
    FL_WB   = 2'd2,
    FL_DONE = 2'd3
  } flush_state_e;

  // Way-select width; a direct-mapped cache still carries one (always zero) bit.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_flush_fsm.sv
// Dirty-line flush sequencer: walks every (set,way) in order and hands dirty lines
// to memory through a valid/ack writeback handshake.
module dcache_flush_fsm
  import dcache_pkg::*;
#(
  parameter int  SETS   = DEF_SETS,
  parameter int  WAYS   = DEF_WAYS,
  parameter int  TAG_W  = DEF_TAG_W,
  parameter int  DATA_W = DEF_DATA_W,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = way_bits(WAYS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_halt_req,
  input  logic                   i_wb_ack,
  input  logic                   i_line_valid,
  input  logic                   i_line_dirty,
  input  logic [TAG_W-1:0]       i_line_tag,
  input  logic [DATA_W-1:0]      i_line_data,
  output logic                   o_busy,
  output logic [IDX_W-1:0]       o_scan_idx,
  output logic [WAY_W-1:0]       o_scan_way,
  output logic                   o_clr_dirty,
  output logic                   o_wb_valid,
  output logic [TAG_W+IDX_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0]      o_wb_data,
  output logic                   o_halt_done
);

  localparam int LINE_W = $clog2(SETS * WAYS);

  flush_state_e      r_state;
  logic [LINE_W-1:0] r_cnt;
  logic              r_halt_done;
  logic              w_last;

  assign w_last = &r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= FL_IDLE;
      r_cnt       <= '0;
      r_halt_done <= 1'b0;
    end else begin
      case (r_state)
        FL_IDLE: begin
          if (i_halt_req) begin
            r_state <= FL_SCAN;
            r_cnt   <= '0;
          end
        end
        FL_SCAN: begin
          if (i_line_valid && i_line_dirty) begin
            r_state <= FL_WB;
          end else if (w_last) begin
            r_state <= FL_DONE;
          end else begin
            r_cnt <= r_cnt + LINE_W'(1);
          end
        end
        FL_WB: begin
          if (i_wb_ack) begin
            if (w_last) begin
              r_state <= FL_DONE;
            end else begin
              r_state <= FL_SCAN;
              r_cnt   <= r_cnt + LINE_W'(1);
            end
          end
        end
        FL_DONE: begin
          if (!i_halt_req) begin
            r_state     <= FL_IDLE;
            r_halt_done <= 1'b0;
          end else begin
            r_halt_done <= 1'b1;
          end
        end
        default: r_state <= FL_IDLE;
      endcase
    end
  end

  // The line counter is {set, way}, so set-major order falls out of a plain increment.
  assign o_scan_idx = r_cnt[LINE_W-1 -: IDX_W];

  if (WAYS > 1) begin : g_way
    assign o_scan_way = r_cnt[WAY_W-1:0];
  end else begin : g_no_way
    assign o_scan_way = 1'b0;
  end

  assign o_busy      = (r_state != FL_IDLE);
  assign o_wb_valid  = (r_state == FL_WB);
  assign o_clr_dirty = (r_state == FL_WB) && i_wb_ack;
  assign o_wb_addr   = {i_line_tag, o_scan_idx};
  assign o_wb_data   = i_line_data;
  assign o_halt_done = r_halt_done;

endmodule

// File: rtl/dcache_assoc_mem.sv
// Set-associative data-cache array: two write ports (port 1 wins), combinational lookup,
// round-robin victim choice and a dirty-line flush engine. Option: DCACHE_WR_BYPASS_EN.
module dcache_assoc_mem
  import dcache_pkg::*;
#(
  parameter int  SETS   = DEF_SETS,
  parameter int  WAYS   = DEF_WAYS,
  parameter int  TAG_W  = DEF_TAG_W,
  parameter int  DATA_W = DEF_DATA_W,
  localparam int IDX_W  = $clog2(SETS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr0_en,
  input  logic [IDX_W-1:0]       wr0_idx,
  input  logic [TAG_W-1:0]       wr0_tag,
  input  logic [DATA_W-1:0]      wr0_data,
  input  logic                   wr0_dirty,
  input  logic                   wr1_en,
  input  logic [IDX_W-1:0]       wr1_idx,
  input  logic [TAG_W-1:0]       wr1_tag,
  input  logic [DATA_W-1:0]      wr1_data,
  input  logic                   wr1_dirty,
  input  logic [IDX_W-1:0]       rd_idx,
  input  logic [TAG_W-1:0]       rd_tag,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   halt_req,
  output logic                   wb_valid,
  output logic [TAG_W+IDX_W-1:0] wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  input  logic                   wb_ack,
  output logic                   halt_done
);

  localparam int WAY_W = way_bits(WAYS);

  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS];
  logic [WAY_W-1:0]  r_rr    [SETS];

  logic              w_busy;
  logic [IDX_W-1:0]  w_scan_idx;
  logic [WAY_W-1:0]  w_scan_way;
  logic              w_clr_dirty;

  logic              w_en        [2];
  logic [IDX_W-1:0]  w_idx       [2];
  logic [TAG_W-1:0]  w_tag       [2];
  logic [DATA_W-1:0] w_data      [2];
  logic              w_dirty     [2];
  logic              w_hit       [2];
  logic [WAY_W-1:0]  w_way       [2];
  logic              w_evict     [2];
  logic              w_set_dirty [2];
  logic              w_go        [2];
  logic              w_same_idx;
  logic              w_same_tag;
  logic              w_p1_dirty;

  function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] v);
    return (32'(v) == WAYS - 1) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    w_en[0]    = wr0_en & ~w_busy;
    w_idx[0]   = wr0_idx;
    w_tag[0]   = wr0_tag;
    w_data[0]  = wr0_data;
    w_dirty[0] = wr0_dirty;
    w_en[1]    = wr1_en & ~w_busy;
    w_idx[1]   = wr1_idx;
    w_tag[1]   = wr1_tag;
    w_data[1]  = wr1_data;
    w_dirty[1] = wr1_dirty;
  end

  // NOTE: every combinational output gets a default before the loops, so no latch is inferred.
  always_comb begin : lookup
    logic             free;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] hit_way;
    for (int p = 0; p < 2; p++) begin
      w_hit[p] = 1'b0;
      hit_way  = '0;
      free     = 1'b0;
      free_way = '0;
      // Descending scan leaves the lowest-numbered invalid way selected.
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (r_valid[w_idx[p]][w] && (r_tag[w_idx[p]][w] == w_tag[p])) begin
          w_hit[p] = 1'b1;
          hit_way  = WAY_W'(w);
        end
        if (!r_valid[w_idx[p]][w]) begin
          free     = 1'b1;
          free_way = WAY_W'(w);
        end
      end
      w_way[p]       = w_hit[p] ? hit_way : (free ? free_way : r_rr[w_idx[p]]);
      w_evict[p]     = !w_hit[p] && !free;
      w_set_dirty[p] = w_dirty[p] | (w_hit[p] & r_dirty[w_idx[p]][w_way[p]]);
    end
  end

  assign w_same_idx = (w_idx[0] == w_idx[1]);
  assign w_same_tag = (w_tag[0] == w_tag[1]);

  // Same-set conflicts: port 0 survives only as a hit on a way port 1 leaves alone.
  always_comb begin
    w_go[1]    = w_en[1];
    w_go[0]    = w_en[0] & ~(w_en[1] & w_same_idx &
                             (w_same_tag | ~w_hit[0] | (w_way[0] == w_way[1])));
    w_p1_dirty = w_set_dirty[1] | (w_en[0] & w_same_idx & w_same_tag & w_dirty[0]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      if (w_go[0]) begin
        r_valid[w_idx[0]][w_way[0]] <= 1'b1;
        r_dirty[w_idx[0]][w_way[0]] <= w_set_dirty[0];
        if (w_evict[0]) r_rr[w_idx[0]] <= rr_next(r_rr[w_idx[0]]);
      end
      if (w_go[1]) begin
        r_valid[w_idx[1]][w_way[1]] <= 1'b1;
        r_dirty[w_idx[1]][w_way[1]] <= w_p1_dirty;
        if (w_evict[1]) r_rr[w_idx[1]] <= rr_next(r_rr[w_idx[1]]);
      end
      if (w_clr_dirty) r_dirty[w_scan_idx][w_scan_way] <= 1'b0;
    end
  end

  // NOTE: tag/data storage has no reset; the valid bits alone decide what is visible.
  always_ff @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (w_go[p]) begin
        r_tag[w_idx[p]][w_way[p]]  <= w_tag[p];
        r_data[w_idx[p]][w_way[p]] <= w_data[p];
      end
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_data  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[rd_idx][w] && (r_tag[rd_idx][w] == rd_tag)) begin
        rd_valid = 1'b1;
        rd_data  = r_data[rd_idx][w];
      end
    end
`ifdef DCACHE_WR_BYPASS_EN
    for (int p = 0; p < 2; p++) begin
      if (w_go[p] && (w_idx[p] == rd_idx) && (w_tag[p] == rd_tag)) begin
        rd_valid = 1'b1;
        rd_data  = w_data[p];
      end
    end
`endif
  end

  dcache_flush_fsm #(
    .SETS   (SETS),
    .WAYS   (WAYS),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_flush (
    .clock        (clock),
    .reset        (reset),
    .i_halt_req   (halt_req),
    .i_wb_ack     (wb_ack),
    .i_line_valid (r_valid[w_scan_idx][w_scan_way]),
    .i_line_dirty (r_dirty[w_scan_idx][w_scan_way]),
    .i_line_tag   (r_tag[w_scan_idx][w_scan_way]),
    .i_line_data  (r_data[w_scan_idx][w_scan_way]),
    .o_busy       (w_busy),
    .o_scan_idx   (w_scan_idx),
    .o_scan_way   (w_scan_way),
    .o_clr_dirty  (w_clr_dirty),
    .o_wb_valid   (wb_valid),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_data),
    .o_halt_done  (halt_done)
  );

endmodule

// File: tb/tb_dcache_assoc_mem.sv
// Self-checking bench for dcache_assoc_mem: directed cases plus randomized dual-port writes
// against a behavioural cache model, flush ordering/handshake and reset-during-writeback.
module tb_dcache_assoc_mem;

  localparam int SETS   = 128;
  localparam int WAYS   = 2;
  localparam int TAG_W  = 22;
  localparam int DATA_W = 64;
  localparam int IDX_W  = $clog2(SETS);
  localparam int AW     = TAG_W + IDX_W;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              wr0_en = 1'b0, wr1_en = 1'b0;
  logic [IDX_W-1:0]  wr0_idx = '0, wr1_idx = '0;
  logic [TAG_W-1:0]  wr0_tag = '0, wr1_tag = '0;
  logic [DATA_W-1:0] wr0_data = '0, wr1_data = '0;
  logic              wr0_dirty = 1'b0, wr1_dirty = 1'b0;
  logic [IDX_W-1:0]  rd_idx = '0;
  logic [TAG_W-1:0]  rd_tag = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              halt_req = 1'b0;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack = 1'b0;
  logic              halt_done;

  dcache_assoc_mem #(
    .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset),
    .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_tag(wr0_tag), .wr0_data(wr0_data), .wr0_dirty(wr0_dirty),
    .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_tag(wr1_tag), .wr1_data(wr1_data), .wr1_dirty(wr1_dirty),
    .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data), .rd_valid(rd_valid),
    .halt_req(halt_req), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ack(wb_ack), .halt_done(halt_done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: each set is a small table of ways plus a victim pointer.
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [DATA_W-1:0] m_data  [SETS][WAYS];
  int                m_rr    [SETS];

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    end
  endtask

  function automatic int m_find(input int idx, input logic [TAG_W-1:0] tag);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) return w;
    return -1;
  endfunction

  function automatic int m_free(input int idx);
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[idx][w]) return w;
    return -1;
  endfunction

  function automatic int m_target(input int idx, input logic [TAG_W-1:0] tag);
    int w;
    w = m_find(idx, tag);
    if (w < 0) w = m_free(idx);
    if (w < 0) w = m_rr[idx];
    return w;
  endfunction

  task automatic m_store(input int idx, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] data, input bit dirty);
    int w;
    w = m_find(idx, tag);
    if (w >= 0) begin
      m_data[idx][w]  = data;
      m_dirty[idx][w] = m_dirty[idx][w] | dirty;
    end else begin
      w = m_free(idx);
      if (w < 0) begin
        w = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % WAYS;
      end
      m_valid[idx][w] = 1;
      m_tag[idx][w]   = tag;
      m_data[idx][w]  = data;
      m_dirty[idx][w] = dirty;
    end
  endtask

  task automatic wr2(input bit e0, input int i0, input logic [TAG_W-1:0] t0,
                     input logic [DATA_W-1:0] d0, input bit y0,
                     input bit e1, input int i1, input logic [TAG_W-1:0] t1,
                     input logic [DATA_W-1:0] d1, input bit y1);
    int h0, g1;
    wr0_en = e0; wr0_idx = IDX_W'(i0); wr0_tag = t0; wr0_data = d0; wr0_dirty = y0;
    wr1_en = e1; wr1_idx = IDX_W'(i1); wr1_tag = t1; wr1_data = d1; wr1_dirty = y1;
    @(posedge clock);
    if (e0 && e1 && i0 == i1) begin
      if (t0 == t1) begin
        m_store(i1, t1, d1, y0 | y1);
      end else begin
        h0 = m_find(i0, t0);
        g1 = m_target(i1, t1);
        m_store(i1, t1, d1, y1);
        if (h0 >= 0 && h0 != g1) m_store(i0, t0, d0, y0);
      end
    end else begin
      if (e0) m_store(i0, t0, d0, y0);
      if (e1) m_store(i1, t1, d1, y1);
    end
    #1;
    wr0_en = 1'b0;
    wr1_en = 1'b0;
  endtask

  task automatic rd_model(input string nm, input int idx, input logic [TAG_W-1:0] tag);
    int w;
    rd_idx = IDX_W'(idx);
    rd_tag = tag;
    #1;
    w = m_find(idx, tag);
    check({nm, "_valid"}, rd_valid, (w >= 0));
    if (w >= 0) check({nm, "_data"}, rd_data, m_data[idx][w]);
    else        check({nm, "_data"}, rd_data, '0);
  endtask

  task automatic rd_expect(input string nm, input int idx, input logic [TAG_W-1:0] tag,
                           input bit ev, input logic [DATA_W-1:0] ed);
    rd_idx = IDX_W'(idx);
    rd_tag = tag;
    #1;
    check({nm, "_valid"}, rd_valid, ev);
    check({nm, "_data"}, rd_data, ed);
  endtask

  task automatic run_flush(input int delay);
    logic [AW-1:0]     qa [$];
    logic [DATA_W-1:0] qd [$];
    int                qs [$];
    int                qw [$];
    int                n_exp, n_wb, cyc, d;
    logic [AW-1:0]     a;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          qa.push_back({m_tag[s][w], IDX_W'(s)});
          qd.push_back(m_data[s][w]);
          qs.push_back(s);
          qw.push_back(w);
        end
    n_exp = qa.size();
    n_wb  = 0;
    cyc   = 0;
    halt_req = 1'b1;
    @(posedge clock); #1;
    while (!halt_done && cyc < 5000) begin
      if (wb_valid) begin
        if (qa.size() == 0) begin
          check("wb_unexpected", wb_valid, 1'b0);
          a = wb_addr;
        end else begin
          a = qa[0];
          check("wb_addr", wb_addr, a);
          check("wb_data", wb_data, qd[0]);
        end
        d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
        for (int i = 0; i < d; i++) begin
          @(posedge clock); #1;
          check("wb_hold_valid", wb_valid, 1'b1);
          check("wb_hold_addr", wb_addr, a);
        end
        wb_ack = 1'b1;
        @(posedge clock); #1;
        wb_ack = 1'b0;
        if (qa.size() != 0) begin
          m_dirty[qs[0]][qw[0]] = 0;
          void'(qa.pop_front()); void'(qd.pop_front());
          void'(qs.pop_front()); void'(qw.pop_front());
        end
        n_wb++;
        cyc += d + 1;
      end else begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    check("flush_done", halt_done, 1'b1);
    check("flush_wb_count", n_wb, n_exp);
    halt_req = 1'b0;
    @(posedge clock); #1;
    check("done_release", halt_done, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    m_reset();
    #12;
    check("reset_wb_valid", wb_valid, 1'b0);
    check("reset_halt_done", halt_done, 1'b0);
    rd_model("reset_rd", 5, 22'h10);
    #10;
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic fill and lookup.
    wr2(0, 0, '0, '0, 0, 1, 5, 22'h10, 64'hAA, 0);
    rd_expect("fill_hit", 5, 22'h10, 1'b1, 64'hAA);
    rd_expect("fill_miss", 5, 22'h11, 1'b0, 64'h0);

    // Replacement: lowest invalid way first, then round-robin victims.
    wr2(0, 0, '0, '0, 0, 1, 7, 22'h1, 64'h101, 0);
    wr2(0, 0, '0, '0, 0, 1, 7, 22'h2, 64'h102, 0);
    wr2(0, 0, '0, '0, 0, 1, 7, 22'h3, 64'h103, 0);
    rd_expect("rr_t1_gone", 7, 22'h1, 1'b0, 64'h0);
    rd_expect("rr_t2_hit", 7, 22'h2, 1'b1, 64'h102);
    rd_expect("rr_t3_hit", 7, 22'h3, 1'b1, 64'h103);
    wr2(0, 0, '0, '0, 0, 1, 7, 22'h4, 64'h104, 0);
    rd_expect("rr_t2_gone", 7, 22'h2, 1'b0, 64'h0);
    rd_expect("rr_t3_kept", 7, 22'h3, 1'b1, 64'h103);
    rd_expect("rr_t4_hit", 7, 22'h4, 1'b1, 64'h104);

    // Port collisions.
    wr2(1, 3, 22'h9, 64'h2, 0, 1, 3, 22'h9, 64'h1, 0);
    rd_expect("same_line_p1", 3, 22'h9, 1'b1, 64'h1);
    wr2(1, 4, 22'h5, 64'h55, 0, 1, 4, 22'h6, 64'h66, 0);
    rd_expect("both_miss_p1", 4, 22'h6, 1'b1, 64'h66);
    rd_expect("both_miss_p0", 4, 22'h5, 1'b0, 64'h0);

    // Randomized dual-port traffic on a few crowded sets.
    for (int it = 0; it < 400; it++) begin
      rd_model("rand_rd", int'($urandom_range(0, 3)), TAG_W'($urandom_range(1, 6)));
      wr2(1'($urandom), int'($urandom_range(0, 3)), TAG_W'($urandom_range(1, 6)),
          {$urandom, $urandom}, 1'($urandom),
          1'($urandom), int'($urandom_range(0, 3)), TAG_W'($urandom_range(1, 6)),
          {$urandom, $urandom}, 1'($urandom));
    end
    run_flush(-1);

    // Stores at both ends of the index range, different sets in one cycle.
    wr2(1, 0, 22'h21, 64'hC0FFEE00, 1, 1, SETS - 1, 22'h22, 64'hC0FFEE7F, 1);
    rd_model("store_lo", 0, 22'h21);
    rd_model("store_hi", SETS - 1, 22'h22);
    run_flush(3);

    // Clean flush latency; a write attempted mid-flush must not land.
    halt_req = 1'b1;
    @(posedge clock); #1;
    cyc = 0;
    wr0_en = 1'b1; wr0_idx = IDX_W'(9); wr0_tag = 22'h33; wr0_data = 64'hDEAD; wr0_dirty = 1'b1;
    @(posedge clock); #1;
    cyc++;
    wr0_en = 1'b0;
    while (!halt_done && cyc < 1000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("clean_flush_cycles", cyc, SETS * WAYS + 1);
    rd_model("busy_write_dropped", 9, 22'h33);
    halt_req = 1'b0;
    @(posedge clock); #1;
    check("clean_done_release", halt_done, 1'b0);

    // Reset while a writeback is pending.
    wr2(0, 0, '0, '0, 0, 1, 10, 22'h5, 64'h1234, 1);
    halt_req = 1'b1;
    cyc = 0;
    while (!wb_valid && cyc < 600) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("rst_wb_seen", wb_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_wb_drop", wb_valid, 1'b0);
    check("rst_halt_done", halt_done, 1'b0);
    m_reset();
    rd_model("rst_line10", 10, 22'h5);
    rd_model("rst_line5", 5, 22'h10);
    halt_req = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clock); #1;
    check("post_rst_wb", wb_valid, 1'b0);
    check("post_rst_done", halt_done, 1'b0);
    rd_model("post_rst_line7", 7, 22'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
